// File: rtl/wb_mprj_splitter.sv
// Wishbone fan-out from the management slave port to N_SLV user cores.
// Adds a bus timeout, decode-error reporting, an edge-latched IRQ aggregator and a control window.
module wb_mprj_splitter #(
   parameter int unsigned N_SLV     = 4,
   parameter int unsigned SLV_AW    = 12,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 wbs_cyc_i,
   input  logic                 wbs_stb_i,
   input  logic                 wbs_we_i,
   input  logic [3:0]           wbs_sel_i,
   input  logic [31:0]          wbs_adr_i,
   input  logic [31:0]          wbs_dat_i,
   output logic                 wbs_ack_o,
   output logic [31:0]          wbs_dat_o,
   output logic [N_SLV-1:0]     s_cyc_o,
   output logic [N_SLV-1:0]     s_stb_o,
   output logic                 s_we_o,
   output logic [3:0]           s_sel_o,
   output logic [SLV_AW-1:0]    s_adr_o,
   output logic [31:0]          s_dat_o,
   input  logic [N_SLV-1:0]     s_ack_i,
   input  logic [32*N_SLV-1:0]  s_dat_i,
   input  logic [N_SLV-1:0]     s_irq_i,
   output logic [2:0]           irq_o
);

   localparam int unsigned IDXW = $clog2(N_SLV + 1);
   localparam int unsigned DECW = SLV_AW + IDXW;
   localparam int unsigned CNTW = 17;

   typedef enum logic [1:0] {IDLE, FWD, RESP} state_t;

   state_t              state_q, state_d;
   logic [IDXW-1:0]     idx_q, idx_d;
   logic [N_SLV-1:0]    cyc_q, cyc_d;
   logic                we_q, we_d;
   logic [3:0]          sel_q, sel_d;
   logic [SLV_AW-1:0]   adr_q, adr_d;
   logic [31:0]         wdat_q, wdat_d;
   logic [CNTW-1:0]     cnt_q, cnt_d;
   logic                ack_q, ack_d;
   logic [31:0]         rdat_q, rdat_d;
   logic [N_SLV-1:0]    en_q, en_d;
   logic [N_SLV-1:0]    pend_q, pend_d;
   logic [N_SLV-1:0]    irq_q, irq_d;
   logic                err_to_q, err_to_d;
   logic                err_dec_q, err_dec_d;
   logic [3:0]          last_to_q, last_to_d;
   logic [2:0]          irq_o_q, irq_o_d;

   logic                req, hit, slv_acc, ctl_acc;
   logic [IDXW-1:0]     req_idx;
   logic [SLV_AW-1:0]   off;
   logic [N_SLV-1:0]    wval_n, pend_clr;
   logic [31:0]         ctl_rd;
   logic                ack_sel;
   logic [31:0]         dat_sel;

   // Address decode and byte-masked write value for the N_SLV-wide registers
   always_comb begin
      req     = wbs_cyc_i & wbs_stb_i;
      hit     = (wbs_adr_i[31:DECW] == BASE_ADDR[31:DECW]);
      req_idx = wbs_adr_i[DECW-1:SLV_AW];
      slv_acc = hit & (req_idx < IDXW'(N_SLV));
      ctl_acc = hit & (req_idx == IDXW'(N_SLV));
      off     = wbs_adr_i[SLV_AW-1:0];
      wval_n  = '0;
      for (int i = 0; i < int'(N_SLV); i++) begin
         wval_n[i] = wbs_dat_i[i] & wbs_sel_i[i/8];
      end
   end

   always_comb begin
      ctl_rd = '0;
      if (off == SLV_AW'(0))       ctl_rd = 32'(en_q);
      else if (off == SLV_AW'(4))  ctl_rd = 32'(pend_q);
      else if (off == SLV_AW'(8))  ctl_rd = {20'h0, last_to_q, 6'h0, err_dec_q, err_to_q};
      else if (off == SLV_AW'(12)) ctl_rd = {16'h5350, 8'(N_SLV), 8'(SLV_AW)};
   end

   // Response mux for the currently selected slave
   always_comb begin
      ack_sel = 1'b0;
      dat_sel = '0;
      for (int i = 0; i < int'(N_SLV); i++) begin
         if (idx_q == IDXW'(i)) begin
            ack_sel = s_ack_i[i];
            dat_sel = s_dat_i[32*i +: 32];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cyc_d     = cyc_q;
      we_d      = we_q;
      sel_d     = sel_q;
      adr_d     = adr_q;
      wdat_d    = wdat_q;
      cnt_d     = cnt_q;
      ack_d     = 1'b0;
      rdat_d    = rdat_q;
      en_d      = en_q;
      irq_d     = s_irq_i;
      err_to_d  = err_to_q;
      err_dec_d = err_dec_q;
      last_to_d = last_to_q;
      pend_clr  = '0;

      case (state_q)
         IDLE: begin
            if (req) begin
               if (slv_acc) begin
                  idx_d   = req_idx;
                  cyc_d   = N_SLV'(1) << req_idx;
                  we_d    = wbs_we_i;
                  sel_d   = wbs_sel_i;
                  adr_d   = off;
                  wdat_d  = wbs_dat_i;
                  cnt_d   = '0;
                  state_d = FWD;
               end else begin
                  state_d = RESP;
                  rdat_d  = ctl_acc ? ctl_rd : 32'h0;
                  if (!ctl_acc) begin
                     err_dec_d = 1'b1;
                  end else if (wbs_we_i) begin
                     if (off == SLV_AW'(0)) begin
                        en_d = wval_n;
                        for (int i = 0; i < int'(N_SLV); i++) begin
                           if (!wbs_sel_i[i/8]) en_d[i] = en_q[i];
                        end
                     end else if (off == SLV_AW'(4)) begin
                        pend_clr = wval_n;
                     end else if (off == SLV_AW'(8)) begin
                        if (wbs_sel_i[0] & wbs_dat_i[0]) err_to_d  = 1'b0;
                        if (wbs_sel_i[0] & wbs_dat_i[1]) err_dec_d = 1'b0;
                     end
                  end
               end
            end
         end
         FWD: begin
            cnt_d = cnt_q + CNTW'(1);
            if (!wbs_cyc_i) begin
               cyc_d   = '0;
               state_d = IDLE;
            end else if (ack_sel) begin
               cyc_d   = '0;
               rdat_d  = dat_sel;
               ack_d   = 1'b1;
               state_d = RESP;
            end else if (cnt_q + CNTW'(1) == CNTW'(TIMEOUT)) begin
               cyc_d     = '0;
               rdat_d    = 32'hFFFF_FFFF;
               ack_d     = 1'b1;
               err_to_d  = 1'b1;
               last_to_d = 4'(idx_q);
               state_d   = RESP;
            end
         end
         RESP: begin
            // Slave responses enter with ack already up; local ones raise it here
            ack_d   = ~ack_q;
            state_d = ack_q ? IDLE : RESP;
         end
         default: state_d = IDLE;
      endcase

      pend_d  = (pend_q & ~pend_clr) | (s_irq_i & ~irq_q);
      irq_o_d = {err_dec_d, err_to_d, |(pend_d & en_d)};
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         cyc_q     <= '0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         adr_q     <= '0;
         wdat_q    <= '0;
         cnt_q     <= '0;
         ack_q     <= 1'b0;
         rdat_q    <= '0;
         en_q      <= '0;
         pend_q    <= '0;
         irq_q     <= '0;
         err_to_q  <= 1'b0;
         err_dec_q <= 1'b0;
         last_to_q <= '0;
         irq_o_q   <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cyc_q     <= cyc_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         adr_q     <= adr_d;
         wdat_q    <= wdat_d;
         cnt_q     <= cnt_d;
         ack_q     <= ack_d;
         rdat_q    <= rdat_d;
         en_q      <= en_d;
         pend_q    <= pend_d;
         irq_q     <= irq_d;
         err_to_q  <= err_to_d;
         err_dec_q <= err_dec_d;
         last_to_q <= last_to_d;
         irq_o_q   <= irq_o_d;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = rdat_q;
   assign s_cyc_o   = cyc_q;
   assign s_stb_o   = cyc_q;
   assign s_we_o    = we_q;
   assign s_sel_o   = sel_q;
   assign s_adr_o   = adr_q;
   assign s_dat_o   = wdat_q;
   assign irq_o     = irq_o_q;

endmodule

// File: tb/tb_wb_mprj_splitter.sv
// Directed bench for wb_mprj_splitter with a transaction-level reference model
// compared against the DUT outputs every cycle.
module tb_wb_mprj_splitter;

   localparam int N  = 4;
   localparam int AW = 12;
   localparam int TO = 255;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]   sel = 4'h0;
   logic [31:0]  adr = 32'h0, wdat = 32'h0;
   logic         wbs_ack_o;
   logic [31:0]  wbs_dat_o;
   logic [N-1:0] s_cyc_o, s_stb_o;
   logic         s_we_o;
   logic [3:0]   s_sel_o;
   logic [AW-1:0] s_adr_o;
   logic [31:0]  s_dat_o;
   logic [N-1:0] s_ack_i = '0;
   logic [32*N-1:0] s_dat_i = '0;
   logic [N-1:0] s_irq_i = '0;
   logic [2:0]   irq_o;

   always #5 clk = ~clk;

   wb_mprj_splitter #(.N_SLV(N), .SLV_AW(AW), .BASE_ADDR(32'h3000_0000), .TIMEOUT(TO)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
      .s_irq_i(s_irq_i), .irq_o(irq_o)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model outputs
   logic [N-1:0] m_stb = '0;
   logic         m_ack = 1'b0;
   logic [31:0]  m_dat = '0;
   logic [2:0]   m_irq = '0;

   initial begin
      int tgt, waited, idx;
      bit pack, eto, edec, old_ack, hit;
      logic [31:0] pdat, a, msk, wv;
      logic [3:0] en, pend, prev, rise, clr, last;
      tgt = -1; waited = 0; pack = 0; eto = 0; edec = 0; pdat = 0;
      en = 0; pend = 0; prev = 0; last = 0;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            tgt = -1; waited = 0; pack = 0; eto = 0; edec = 0; pdat = 0;
            en = 0; pend = 0; prev = 0; last = 0;
            m_stb = 0; m_ack = 0; m_dat = 0; m_irq = 0;
         end else begin
            rise = s_irq_i & ~prev;
            prev = s_irq_i;
            clr = 0;
            old_ack = m_ack;
            m_ack = 0;
            if (pack) begin
               pack = 0; m_ack = 1; m_dat = pdat;
            end else if (tgt >= 0) begin
               waited++;
               if (!cyc) tgt = -1;
               else if (s_ack_i[tgt]) begin
                  m_ack = 1; m_dat = s_dat_i[32*tgt +: 32]; tgt = -1;
               end else if (waited == TO) begin
                  m_ack = 1; m_dat = 32'hFFFF_FFFF; eto = 1; last = 4'(tgt); tgt = -1;
               end
            end else if (!old_ack && cyc && stb) begin
               a   = adr;
               idx = int'((a >> AW) & 32'h7);
               hit = ((a >> 15) == (32'h3000_0000 >> 15));
               if (hit && idx < N) begin
                  tgt = idx; waited = 0;
               end else if (hit && idx == N) begin
                  pack = 1;
                  case (a & 32'hFFF)
                     32'h0:   pdat = 32'(en);
                     32'h4:   pdat = 32'(pend);
                     32'h8:   pdat = (32'(last) << 8) | (32'(edec) << 1) | 32'(eto);
                     32'hC:   pdat = 32'h5350_040C;
                     default: pdat = 0;
                  endcase
                  if (we) begin
                     msk = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
                     wv  = wdat & msk;
                     case (a & 32'hFFF)
                        32'h0: en = (en & ~msk[3:0]) | wv[3:0];
                        32'h4: clr = wv[3:0];
                        32'h8: begin
                           if (wv[0]) eto = 0;
                           if (wv[1]) edec = 0;
                        end
                        default: ;
                     endcase
                  end
               end else begin
                  pack = 1; pdat = 0; edec = 1;
               end
            end
            pend  = (pend & ~clr) | rise;
            m_stb = (tgt >= 0) ? 4'(1 << tgt) : 4'h0;
            m_irq = {edec, eto, |(pend & en)};
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         check("stb", 32'(s_stb_o), 32'(m_stb));
         check("cyc", 32'(s_cyc_o), 32'(m_stb));
         check("ack", 32'(wbs_ack_o), 32'(m_ack));
         if (m_ack) check("rdata", wbs_dat_o, m_dat);
         check("irq", 32'(irq_o), 32'(m_irq));
      end
   end

   task automatic bus_req(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
      @(posedge clk); #1;
      cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
   endtask

   task automatic bus_end();
      cyc = 0; stb = 0; we = 0;
   endtask

   task automatic wait_ack(input int maxc, output int n, output logic [31:0] d);
      bit got;
      got = 0; n = 0; d = 0;
      while (!got && n < maxc) begin
         @(posedge clk); #1;
         n++;
         if (wbs_ack_o) begin
            got = 1; d = wbs_dat_o;
         end
      end
      check("ack_seen", 32'(got), 32'h1);
   endtask

   task automatic ctl(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output int n);
      bus_req(a, w, d, s);
      wait_ack(10, n, rd);
      bus_end();
   endtask

   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   logic [31:0] tbl_a [5] = '{32'h3100_0000, 32'h3000_400C, 32'h3000_4002, 32'h3000_5000, 32'h3000_4010};
   logic [31:0] tbl_d [5] = '{32'h0, 32'h5350_040C, 32'h0, 32'h0, 32'h0};

   initial begin
      logic [31:0] rd;
      int n, hi, acks;
      bit got;

      #1 rst = 1;
      repeat (3) @(negedge clk);
      check("rst_ack", 32'(wbs_ack_o), 32'h0);
      check("rst_dat", wbs_dat_o, 32'h0);
      check("rst_stb", 32'(s_stb_o), 32'h0);
      check("rst_irq", 32'(irq_o), 32'h0);
      @(posedge clk); #1 rst = 0;

      // Slave 1 write
      bus_req(32'h3000_1004, 1'b1, 32'hCAFE_0001, 4'hF);
      @(posedge clk); #1;
      check("t1_stb", 32'(s_stb_o), 32'h2);
      check("t1_adr", 32'(s_adr_o), 32'h004);
      check("t1_dat", s_dat_o, 32'hCAFE_0001);
      check("t1_we", 32'(s_we_o), 32'h1);
      repeat (2) begin @(posedge clk); #1; end
      check("t1_early", 32'(wbs_ack_o), 32'h0);
      s_ack_i = 4'b0010;
      @(posedge clk); #1;
      s_ack_i = 0;
      check("t1_ack", 32'(wbs_ack_o), 32'h1);
      check("t1_drop", 32'(s_stb_o), 32'h0);
      bus_end();
      @(posedge clk); #1;
      check("t1_onecyc", 32'(wbs_ack_o), 32'h0);

      // Slave 3 read, with a stray ack from slave 0 first
      bus_req(32'h3000_3010, 1'b0, 32'h0, 4'hF);
      @(posedge clk); #1;
      check("t2_stb", 32'(s_stb_o), 32'h8);
      check("t2_adr", 32'(s_adr_o), 32'h010);
      s_dat_i = {32'h1234_5678, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
      s_ack_i = 4'b0001;
      @(posedge clk); #1;
      s_ack_i = 0;
      check("t2_stray", 32'(wbs_ack_o), 32'h0);
      s_ack_i = 4'b1000;
      wait_ack(5, n, rd);
      s_ack_i = 0;
      bus_end();
      check("t2_lat", 32'(n), 32'h1);
      check("t2_data", rd, 32'h1234_5678);

      // Slave 2 never answers
      bus_req(32'h3000_2000, 1'b0, 32'h0, 4'hF);
      got = 0; hi = 0; rd = 0;
      for (int k = 0; k < 400 && !got; k++) begin
         @(posedge clk); #1;
         if (wbs_ack_o) begin
            got = 1; rd = wbs_dat_o;
         end else if (s_stb_o[2]) hi++;
      end
      bus_end();
      check("to_got", 32'(got), 32'h1);
      check("to_len", 32'(hi), 32'd255);
      check("to_data", rd, 32'hFFFF_FFFF);
      check("to_irq", 32'(irq_o[1]), 32'h1);
      ctl(32'h3000_4008, 1'b0, 32'h0, 4'hF, rd, n);
      check("to_status", rd, 32'h0000_0201);
      ctl(32'h3000_4008, 1'b1, 32'h1, 4'hF, rd, n);
      check("to_clr_irq", 32'(irq_o[1]), 32'h0);
      ctl(32'h3000_4008, 1'b0, 32'h0, 4'hF, rd, n);
      check("to_status2", rd, 32'h0000_0200);

      // Decode errors and control reads
      for (int i = 0; i < 5; i++) begin
         ctl(tbl_a[i], 1'b0, 32'h0, 4'hF, rd, n);
         check("dec_lat", 32'(n), 32'h2);
         check("dec_data", rd, tbl_d[i]);
         if (i == 0) check("dec_irq", 32'(irq_o[2]), 32'h1);
      end
      ctl(32'h3000_4008, 1'b1, 32'h2, 4'hF, rd, n);
      check("dec_clr", 32'(irq_o[2]), 32'h0);

      // IRQ aggregation
      ctl(32'h3000_4000, 1'b1, 32'h5, 4'hF, rd, n);
      ctl(32'h3000_4000, 1'b1, 32'hA, 4'h0, rd, n);
      ctl(32'h3000_4000, 1'b0, 32'h0, 4'hF, rd, n);
      check("en_sel", rd, 32'h5);
      @(posedge clk); #1 s_irq_i = 4'b0011;
      @(posedge clk); #1 s_irq_i = 4'b0000;
      ctl(32'h3000_4004, 1'b0, 32'h0, 4'hF, rd, n);
      check("pend_a", rd, 32'h3);
      check("irq0_a", 32'(irq_o[0]), 32'h1);
      bus_req(32'h3000_4004, 1'b1, 32'h1, 4'hF);
      s_irq_i = 4'b0001;
      wait_ack(10, n, rd);
      bus_end();
      s_irq_i = 4'b0000;
      ctl(32'h3000_4004, 1'b0, 32'h0, 4'hF, rd, n);
      check("pend_setwins", rd, 32'h3);
      ctl(32'h3000_4004, 1'b1, 32'h3, 4'hF, rd, n);
      ctl(32'h3000_4004, 1'b0, 32'h0, 4'hF, rd, n);
      check("pend_clr", rd, 32'h0);
      check("irq0_clr", 32'(irq_o[0]), 32'h0);
      @(posedge clk); #1 s_irq_i = 4'b0010;
      @(posedge clk); #1 s_irq_i = 4'b0000;
      @(posedge clk); #1;
      check("irq0_masked", 32'(irq_o[0]), 32'h0);
      @(posedge clk); #1 s_irq_i = 4'b0100;
      @(posedge clk); #1;
      check("irq0_en2", 32'(irq_o[0]), 32'h1);
      ctl(32'h3000_4004, 1'b0, 32'h0, 4'hF, rd, n);
      check("pend_b", rd, 32'h6);

      // Reset in the middle of a forwarded access
      bus_req(32'h3000_1000, 1'b0, 32'h0, 4'hF);
      @(posedge clk); #1;
      check("rf_stb", 32'(s_stb_o), 32'h2);
      #2 rst = 1;
      #1;
      check("rf_stb0", 32'(s_stb_o), 32'h0);
      check("rf_cyc0", 32'(s_cyc_o), 32'h0);
      check("rf_ack0", 32'(wbs_ack_o), 32'h0);
      check("rf_irq0", 32'(irq_o), 32'h0);
      bus_end();
      @(posedge clk); #1 rst = 0;
      s_ack_i = 4'b0010;
      acks = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         s_ack_i = 0;
         if (wbs_ack_o) acks++;
      end
      check("rf_late_ack", 32'(acks), 32'h0);
      s_irq_i = 4'b0000;
      ctl(32'h3000_4000, 1'b0, 32'h0, 4'hF, rd, n);
      check("rf_en", rd, 32'h0);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
